// File: rtl/rename_regfile_mc_if.sv
// Bus bundle between dispatch/ROB/issue and the rename register file.
// master drives reservations, commits and read addresses; slave returns operands and busy count.
interface rename_regfile_mc_if #(
  parameter int DATA_W      = 32,
  parameter int REG_ADDR_W  = 5,
  parameter int RSV_ID_W    = 4,
  parameter int N_RD_PORTS  = 3,
  parameter int N_CMT_PORTS = 2
);
  logic                              pred_miss;
  logic                              rsv;
  logic [REG_ADDR_W-1:0]             rsv_addr;
  logic [RSV_ID_W-1:0]               rsv_id;
  logic [N_CMT_PORTS-1:0]            cmt_we;
  logic [N_CMT_PORTS*RSV_ID_W-1:0]   cmt_id;
  logic [N_CMT_PORTS*REG_ADDR_W-1:0] cmt_addr;
  logic [N_CMT_PORTS*DATA_W-1:0]     cmt_data;
  logic [N_RD_PORTS*REG_ADDR_W-1:0]  rd_addr;
  logic [N_RD_PORTS*DATA_W-1:0]      rd_data;
  logic [N_RD_PORTS*RSV_ID_W-1:0]    rd_id;
  logic [N_RD_PORTS-1:0]             rd_filled;
  logic [REG_ADDR_W:0]               busy_count;

  modport master (
    output pred_miss, rsv, rsv_addr, rsv_id, cmt_we, cmt_id, cmt_addr, cmt_data, rd_addr,
    input  rd_data, rd_id, rd_filled, busy_count
  );

  modport slave (
    input  pred_miss, rsv, rsv_addr, rsv_id, cmt_we, cmt_id, cmt_addr, cmt_data, rd_addr,
    output rd_data, rd_id, rd_filled, busy_count
  );
endinterface

// File: rtl/rename_regfile_mc.sv
// Architectural register file with per-register rename tag scoreboard, multi-port commit and flush.
// Optional macro RF_CMT_BYPASS_EN forwards same-cycle filling commits to the read ports.
module rename_regfile_mc #(
  parameter int DATA_W      = 32,
  parameter int REG_ADDR_W  = 5,
  parameter int RSV_ID_W    = 4,
  parameter int N_RD_PORTS  = 3,
  parameter int N_CMT_PORTS = 2,
  parameter int ZERO_REG    = 1
) (
  input logic                clk,
  input logic                nrst,
  rename_regfile_mc_if.slave bus
);
  localparam int DEPTH = 2 ** REG_ADDR_W;
  localparam int CNT_W = REG_ADDR_W + 1;

  logic [DATA_W-1:0]     data_q [DEPTH];
  logic [DATA_W-1:0]     data_d [DEPTH];
  logic [RSV_ID_W-1:0]   tag_q  [DEPTH];
  logic [RSV_ID_W-1:0]   tag_d  [DEPTH];
  logic [DEPTH-1:0]      filled_q, filled_d;
  logic [CNT_W-1:0]      busy_q, busy_d;

  logic [REG_ADDR_W-1:0] cmt_addr_v [N_CMT_PORTS];
  logic [RSV_ID_W-1:0]   cmt_id_v   [N_CMT_PORTS];
  logic [DATA_W-1:0]     cmt_data_v [N_CMT_PORTS];
  logic [N_CMT_PORTS-1:0] cmt_ok, cmt_fill;
  logic                  rsv_ok;

  logic [REG_ADDR_W-1:0] rd_addr_v   [N_RD_PORTS];
  logic [DATA_W-1:0]     rd_data_v   [N_RD_PORTS];
  logic [RSV_ID_W-1:0]   rd_id_v     [N_RD_PORTS];
  logic [N_RD_PORTS-1:0] rd_filled_v;

  for (genvar p = 0; p < N_CMT_PORTS; p++) begin : g_cmt
    assign cmt_addr_v[p] = bus.cmt_addr[p*REG_ADDR_W +: REG_ADDR_W];
    assign cmt_id_v[p]   = bus.cmt_id[p*RSV_ID_W +: RSV_ID_W];
    assign cmt_data_v[p] = bus.cmt_data[p*DATA_W +: DATA_W];
  end

  for (genvar r = 0; r < N_RD_PORTS; r++) begin : g_rd
    assign rd_addr_v[r]                       = bus.rd_addr[r*REG_ADDR_W +: REG_ADDR_W];
    assign bus.rd_data[r*DATA_W +: DATA_W]    = rd_data_v[r];
    assign bus.rd_id[r*RSV_ID_W +: RSV_ID_W]  = rd_id_v[r];
    assign bus.rd_filled[r]                   = rd_filled_v[r];
  end

  assign bus.busy_count = busy_q;

  // A reservation is dropped by a flush and never lands on the hardwired zero register.
  assign rsv_ok = bus.rsv && !bus.pred_miss && !(ZERO_REG != 0 && bus.rsv_addr == '0);

  always_comb begin
    for (int p = 0; p < N_CMT_PORTS; p++) begin
      cmt_ok[p]   = bus.cmt_we[p] && !(ZERO_REG != 0 && cmt_addr_v[p] == '0);
      cmt_fill[p] = cmt_ok[p] && !bus.pred_miss
                    && !(rsv_ok && bus.rsv_addr == cmt_addr_v[p])
                    && tag_q[cmt_addr_v[p]] == cmt_id_v[p];
    end
  end

  // NOTE: next state is built with blocking assignments in always_comb so later
  // statements (higher port, reservation, flush) override earlier ones in order.
  always_comb begin
    data_d   = data_q;
    tag_d    = tag_q;
    filled_d = filled_q;
    for (int p = 0; p < N_CMT_PORTS; p++) begin
      if (cmt_ok[p])   data_d[cmt_addr_v[p]]   = cmt_data_v[p];
      if (cmt_fill[p]) filled_d[cmt_addr_v[p]] = 1'b1;
    end
    if (rsv_ok) begin
      tag_d[bus.rsv_addr]    = bus.rsv_id;
      filled_d[bus.rsv_addr] = 1'b0;
    end
    if (bus.pred_miss) begin
      filled_d = '1;
      tag_d    = '{default: '0};
    end
    busy_d = '0;
    for (int i = 0; i < DEPTH; i++) busy_d = busy_d + CNT_W'(!filled_d[i]);
  end

  // NOTE: the storage array is reset explicitly because a mid-run reset must
  // discard committed values, not just the scoreboard.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      data_q   <= '{default: '0};
      tag_q    <= '{default: '0};
      filled_q <= '1;
      busy_q   <= '0;
    end else begin
      data_q   <= data_d;
      tag_q    <= tag_d;
      filled_q <= filled_d;
      busy_q   <= busy_d;
    end
  end

  always_comb begin
    for (int r = 0; r < N_RD_PORTS; r++) begin
      rd_data_v[r]   = data_q[rd_addr_v[r]];
      rd_id_v[r]     = tag_q[rd_addr_v[r]];
      rd_filled_v[r] = filled_q[rd_addr_v[r]];
`ifdef RF_CMT_BYPASS_EN
      for (int p = 0; p < N_CMT_PORTS; p++) begin
        if (cmt_fill[p] && cmt_addr_v[p] == rd_addr_v[r]) begin
          rd_data_v[r]   = cmt_data_v[p];
          rd_filled_v[r] = 1'b1;
        end
      end
`endif
      if (ZERO_REG != 0 && rd_addr_v[r] == '0) begin
        rd_data_v[r]   = '0;
        rd_id_v[r]     = '0;
        rd_filled_v[r] = 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_rename_regfile_mc.sv
// Self-checking bench for rename_regfile_mc: directed table, corner sequences,
// and randomized traffic against a register-centric reference model.
module tb_rename_regfile_mc;
  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int IW    = 4;
  localparam int NR    = 3;
  localparam int NC    = 2;
  localparam int DEPTH = 32;

  logic clk  = 1'b0;
  logic nrst = 1'b1;
  always #5 clk = ~clk;

  rename_regfile_mc_if rf_bus ();
  rename_regfile_mc dut (.clk(clk), .nrst(nrst), .bus(rf_bus));

  int vectors     = 0;
  int miscompares = 0;

  logic [DW-1:0] m_data   [DEPTH];
  logic [IW-1:0] m_tag    [DEPTH];
  logic          m_filled [DEPTH];
  int            m_busy;

  typedef struct {
    logic          pm;
    logic          rsv;
    logic [AW-1:0] ra;
    logic [IW-1:0] rid;
    logic [NC-1:0] we;
    logic [AW-1:0] a0;
    logic [IW-1:0] i0;
    logic [DW-1:0] d0;
    logic [AW-1:0] a1;
    logic [IW-1:0] i1;
    logic [DW-1:0] d1;
    logic [AW-1:0] chk;
    logic [DW-1:0] e_data;
    logic [IW-1:0] e_id;
    logic          e_filled;
    logic [AW:0]   e_busy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic pm, logic rsv, logic [AW-1:0] ra, logic [IW-1:0] rid,
                              logic [NC-1:0] we, logic [AW-1:0] a0, logic [IW-1:0] i0,
                              logic [DW-1:0] d0, logic [AW-1:0] a1, logic [IW-1:0] i1,
                              logic [DW-1:0] d1, logic [AW-1:0] chk, logic [DW-1:0] e_data,
                              logic [IW-1:0] e_id, logic e_filled, logic [AW:0] e_busy);
    vec_t v;
    v.pm = pm; v.rsv = rsv; v.ra = ra; v.rid = rid; v.we = we;
    v.a0 = a0; v.i0 = i0; v.d0 = d0; v.a1 = a1; v.i1 = i1; v.d1 = d1;
    v.chk = chk; v.e_data = e_data; v.e_id = e_id; v.e_filled = e_filled; v.e_busy = e_busy;
    return v;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_idle();
    rf_bus.pred_miss = 1'b0;
    rf_bus.rsv       = 1'b0;
    rf_bus.rsv_addr  = '0;
    rf_bus.rsv_id    = '0;
    rf_bus.cmt_we    = '0;
    rf_bus.cmt_id    = '0;
    rf_bus.cmt_addr  = '0;
    rf_bus.cmt_data  = '0;
    rf_bus.rd_addr   = '0;
  endtask

  task automatic set_cmt(int p, logic [AW-1:0] a, logic [IW-1:0] id, logic [DW-1:0] d);
    rf_bus.cmt_addr[p*AW +: AW] = a;
    rf_bus.cmt_id[p*IW +: IW]   = id;
    rf_bus.cmt_data[p*DW +: DW] = d;
  endtask

  task automatic model_reset();
    for (int r = 0; r < DEPTH; r++) begin
      m_data[r] = '0; m_tag[r] = '0; m_filled[r] = 1'b1;
    end
    m_busy = 0;
  endtask

  // Per register: last commit port hitting it supplies data; any tag-matching commit
  // fills it; a live reservation beats that; a flush beats everything for tag/filled.
  task automatic model_update();
    logic pm;
    pm = rf_bus.pred_miss;
    m_busy = 0;
    for (int r = 1; r < DEPTH; r++) begin
      logic matched, reserved;
      matched = 1'b0;
      for (int p = 0; p < NC; p++) begin
        if (rf_bus.cmt_we[p] && rf_bus.cmt_addr[p*AW +: AW] == AW'(r)) begin
          m_data[r] = rf_bus.cmt_data[p*DW +: DW];
          if (rf_bus.cmt_id[p*IW +: IW] == m_tag[r]) matched = 1'b1;
        end
      end
      reserved = rf_bus.rsv && !pm && rf_bus.rsv_addr == AW'(r);
      if (pm) begin
        m_filled[r] = 1'b1; m_tag[r] = '0;
      end else if (reserved) begin
        m_filled[r] = 1'b0; m_tag[r] = rf_bus.rsv_id;
      end else if (matched) begin
        m_filled[r] = 1'b1;
      end
      if (!m_filled[r]) m_busy++;
    end
  endtask

  task automatic model_read(input logic [AW-1:0] a, output logic [DW-1:0] d,
                            output logic [IW-1:0] t, output logic f);
    d = m_data[a]; t = m_tag[a]; f = m_filled[a];
`ifdef RF_CMT_BYPASS_EN
    if (!rf_bus.pred_miss && !(rf_bus.rsv && rf_bus.rsv_addr == a)) begin
      for (int p = 0; p < NC; p++)
        if (rf_bus.cmt_we[p] && rf_bus.cmt_addr[p*AW +: AW] == a
            && rf_bus.cmt_id[p*IW +: IW] == m_tag[a]) begin
          d = rf_bus.cmt_data[p*DW +: DW]; f = 1'b1;
        end
    end
`endif
    if (a == '0) begin
      d = '0; t = '0; f = 1'b1;
    end
  endtask

  task automatic check_port(string name, int p, logic [DW-1:0] d, logic [IW-1:0] t, logic f);
    check({name, "_data"},   rf_bus.rd_data[p*DW +: DW], d);
    check({name, "_id"},     rf_bus.rd_id[p*IW +: IW], t);
    check({name, "_filled"}, rf_bus.rd_filled[p], f);
  endtask

  task automatic check_model_all(string name);
    logic [DW-1:0] d; logic [IW-1:0] t; logic f;
    for (int p = 0; p < NR; p++) begin
      model_read(rf_bus.rd_addr[p*AW +: AW], d, t, f);
      check_port($sformatf("%s_p%0d", name, p), p, d, t, f);
    end
    check({name, "_busy"}, 64'(rf_bus.busy_count), 64'(m_busy));
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  initial begin
    logic [DW-1:0] byp_d;
    logic          byp_f;

    // Reset: every register reads zero/filled, nothing busy.
    drive_idle();
    #2 nrst = 1'b0;
    model_reset();
    for (int r = 0; r < DEPTH; r++) begin
      for (int p = 0; p < NR; p++) rf_bus.rd_addr[p*AW +: AW] = AW'((r + p) % DEPTH);
      #1;
      if (r % 8 == 0) check_model_all($sformatf("reset_r%0d", r));
      else check_port($sformatf("reset_r%0d", r), 0, '0, '0, 1'b1);
    end
    check("reset_busy", 64'(rf_bus.busy_count), 64'd0);
    @(negedge clk) nrst = 1'b1;

    //       pm rsv ra rid we a0 i0 d0            a1 i1 d1      chk e_data        e_id f busy
    tbl.push_back(mk(0, 1, 5, 3, 0, 0, 0, 0,             0, 0, 0,     5,  0,            3, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 5, 3, 32'hDEAD_BEEF, 0, 0, 0,     5,  32'hDEAD_BEEF, 3, 1, 0));
    tbl.push_back(mk(0, 1, 7, 2, 0, 0, 0, 0,             0, 0, 0,     7,  0,            2, 0, 1));
    tbl.push_back(mk(0, 1, 7, 9, 0, 0, 0, 0,             0, 0, 0,     7,  0,            9, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 7, 2, 32'h11,        0, 0, 0,     7,  32'h11,       9, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 7, 9, 32'h22,        0, 0, 0,     7,  32'h22,       9, 1, 0));
    tbl.push_back(mk(0, 1, 4, 6, 0, 0, 0, 0,             0, 0, 0,     4,  0,            6, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 3, 4, 6, 32'hA,         4, 6, 32'hB, 4,  32'hB,        6, 1, 0));
    tbl.push_back(mk(0, 1, 6, 5, 0, 0, 0, 0,             0, 0, 0,     6,  0,            5, 0, 1));
    tbl.push_back(mk(0, 1, 6, 1, 1, 6, 5, 32'h5,         0, 0, 0,     6,  32'h5,        1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 6, 1, 32'h66,        0, 0, 0,     6,  32'h66,       1, 1, 0));
    tbl.push_back(mk(0, 1, 9, 7, 0, 0, 0, 0,             0, 0, 0,     9,  0,            7, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 3, 9, 7, 32'h1,         9, 8, 32'h2, 9,  32'h2,        7, 1, 0));
    tbl.push_back(mk(0, 1, 1, 1, 0, 0, 0, 0,             0, 0, 0,     1,  0,            1, 0, 1));
    tbl.push_back(mk(0, 1, 2, 2, 0, 0, 0, 0,             0, 0, 0,     2,  0,            2, 0, 2));
    tbl.push_back(mk(0, 1, 3, 3, 0, 0, 0, 0,             0, 0, 0,     3,  0,            3, 0, 3));
    tbl.push_back(mk(1, 1, 8, 4, 0, 0, 0, 0,             0, 0, 0,     8,  0,            0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,             0, 0, 0,     3,  0,            0, 1, 0));
    tbl.push_back(mk(0, 1, 0, 5, 1, 0, 0, 32'hFF,        0, 0, 0,     0,  0,            0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 2, 0, 0, 0,             0, 0, 32'hFF, 0, 0,            0, 1, 0));
    tbl.push_back(mk(0, 1, 10, 2, 0, 0, 0, 0,            0, 0, 0,     10, 0,            2, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 1, 10, 5, 32'h33,       0, 0, 0,     10, 32'h33,       0, 1, 0));

    foreach (tbl[i]) begin
      rf_bus.pred_miss = tbl[i].pm;
      rf_bus.rsv       = tbl[i].rsv;
      rf_bus.rsv_addr  = tbl[i].ra;
      rf_bus.rsv_id    = tbl[i].rid;
      rf_bus.cmt_we    = tbl[i].we;
      set_cmt(0, tbl[i].a0, tbl[i].i0, tbl[i].d0);
      set_cmt(1, tbl[i].a1, tbl[i].i1, tbl[i].d1);
      tick();
      drive_idle();
      rf_bus.rd_addr[0 +: AW] = tbl[i].chk;
      #1;
      check_port($sformatf("vec%0d", i), 0, tbl[i].e_data, tbl[i].e_id, tbl[i].e_filled);
      check($sformatf("vec%0d_busy", i), 64'(rf_bus.busy_count), 64'(tbl[i].e_busy));
    end

    // Same-cycle visibility of a filling commit on a read port.
    rf_bus.rsv = 1'b1; rf_bus.rsv_addr = 5; rf_bus.rsv_id = 4;
    tick();
    drive_idle();
    rf_bus.cmt_we = 2'b01;
    set_cmt(0, 5, 4, 32'h77);
    rf_bus.rd_addr[0 +: AW] = 5;
    #1;
`ifdef RF_CMT_BYPASS_EN
    byp_d = 32'h77;         byp_f = 1'b1;
`else
    byp_d = 32'hDEAD_BEEF;  byp_f = 1'b0;
`endif
    check_port("bypass_same", 0, byp_d, 4'd4, byp_f);
    tick();
    drive_idle();
    rf_bus.rd_addr[0 +: AW] = 5;
    #1;
    check_port("bypass_next", 0, 32'h77, 4'd4, 1'b1);

    // Randomized traffic on a small address window to force collisions.
    for (int c = 0; c < 400; c++) begin
      rf_bus.pred_miss = ($urandom_range(15) == 0);
      rf_bus.rsv       = 1'($urandom_range(1));
      rf_bus.rsv_addr  = AW'($urandom_range(7));
      rf_bus.rsv_id    = IW'($urandom_range(3));
      for (int p = 0; p < NC; p++) begin
        logic [AW-1:0] a;
        a = AW'($urandom_range(7));
        rf_bus.cmt_we[p] = 1'($urandom_range(1));
        set_cmt(p, a, ($urandom_range(3) == 0) ? IW'($urandom_range(15)) : m_tag[a], $urandom);
      end
      for (int p = 0; p < NR; p++)
        rf_bus.rd_addr[p*AW +: AW] = ($urandom_range(7) == 0) ? AW'($urandom) : AW'($urandom_range(7));
      #1;
      check_model_all($sformatf("rand%0d", c));
      tick();
    end

    // Reset mid-traffic: state must clear immediately, without a clock edge.
    rf_bus.rsv = 1'b1; rf_bus.rsv_addr = 3; rf_bus.rsv_id = 2;
    #2 nrst = 1'b0;
    drive_idle();
    model_reset();
    for (int r = 1; r < 8; r++) begin
      for (int p = 0; p < NR; p++) rf_bus.rd_addr[p*AW +: AW] = AW'(r);
      #1;
      check_port($sformatf("midreset_r%0d", r), 0, '0, '0, 1'b1);
    end
    check("midreset_busy", 64'(rf_bus.busy_count), 64'd0);
    @(negedge clk) nrst = 1'b1;
    tick();
    check_model_all("post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/rename_regfile_mc.md
Name: rename_regfile_mc

Overview:
- Parametrised successor to the core's single-commit architectural register file with rename tags.
- Holds the architectural values plus a per-register busy/tag (ROB id) scoreboard.
- Accepts one reservation per cycle from dispatch and N_CMT_PORTS commits per cycle from the ROB.
- Serves N_RD_PORTS operand reads to issue, supports a full flush on branch mispredict, and exports an outstanding-reservation count.

Parameters:
DATA_W, 32, data width per register
REG_ADDR_W, 5, register address width; depth = 2**REG_ADDR_W
RSV_ID_W, 4, ROB tag width
N_RD_PORTS, 3, number of read ports
N_CMT_PORTS, 2, number of commit (write) ports
ZERO_REG, 1, 1: register 0 reads 0, never reserved or written

Ports:
clk  in  1  clock
nrst  in  1  asynchronous active-low reset
pred_miss  in  1  flush all reservations
rsv  in  1  reserve the destination register
rsv_addr  in  REG_ADDR_W  destination register
rsv_id  in  RSV_ID_W  ROB tag of the reserving instruction
cmt_we  in  N_CMT_PORTS  per-port commit valid
cmt_id  in  N_CMT_PORTS*RSV_ID_W  committing ROB tag
cmt_addr  in  N_CMT_PORTS*REG_ADDR_W  committing register
cmt_data  in  N_CMT_PORTS*DATA_W  committing value
rd_addr  in  N_RD_PORTS*REG_ADDR_W  read addresses
rd_data  out  N_RD_PORTS*DATA_W  register value
rd_id  out  N_RD_PORTS*RSV_ID_W  pending tag (valid when rd_filled=0)
rd_filled  out  N_RD_PORTS  1 = value final, 0 = wait for rd_id
busy_count  out  REG_ADDR_W+1  number of registers with filled=0 (registered)

Behaviour:
- Reset (nrst=0, async): all data=0, tag=0, filled=1, busy_count=0. Reset mid-operation discards all reservations and values. All read outputs track the reset state combinationally.
- State per register: data[DATA_W], tag[RSV_ID_W], filled[1]. All updates happen on posedge clk.
- Reads: combinational, zero latency, from registered state. rd_data = data[a], rd_id = tag[a], rd_filled = filled[a].
- Commit, port p with cmt_we[p]=1:
  - data[cmt_addr[p]] <= cmt_data[p], unconditionally.
  - filled <= 1 only if tag[cmt_addr[p]] == cmt_id[p] and no reservation hits the same register this cycle.
- Multiple commit ports writing the same register in one cycle: the highest port index wins for data. filled is set if any matching port's tag matches.
- Reservation (rsv=1, pred_miss=0): tag[rsv_addr] <= rsv_id, filled[rsv_addr] <= 0.
  - Reservation beats a same-cycle commit on filled and tag. The commit's data is still written.
  - Re-reserving an already-busy register overwrites its tag; a later commit with the old tag writes data but leaves filled=0.
- pred_miss=1: every filled <= 1, every tag <= 0. The same-cycle rsv is dropped. Same-cycle commit data is still written.
- ZERO_REG=1: address 0 reads data 0, filled 1, tag 0. Reservations and commits to address 0 are ignored.
- busy_count: registered popcount of next-state ~filled, so it is visible the cycle after the update. Range 0..2**REG_ADDR_W.

Optional Feature:
- Macro RF_CMT_BYPASS_EN.
- Defined: if a read address equals a same-cycle commit address and that commit would set filled (tag match, no overriding rsv/pred_miss), the read returns the commit data with rd_filled=1 in the same cycle. With multiple matching ports, the highest index wins. This is a combinational path from cmt_* to rd_*.
- Undefined: reads see registered state only; the committed value is visible one cycle later.

Test Plan:
1. Reset, then read all regs -> rd_data=0, rd_filled=1, busy_count=0. Assert nrst mid-traffic -> same state immediately.
2. rsv addr 5 id 3; next cycle read 5 -> rd_filled=0, rd_id=3, busy_count=1. Commit port0 addr 5 id 3 data 0xDEAD_BEEF; next cycle -> rd_data=0xDEADBEEF, rd_filled=1, busy_count=0.
3. rsv addr 7 id 2, then rsv addr 7 id 9; commit addr 7 id 2 data 0x11 -> data=0x11, filled=0, rd_id=9. Commit id 9 data 0x22 -> filled=1, data 0x22.
4. Same cycle: port0 and port1 both commit addr 4 data 0xA and 0xB with the matching tag -> data 0xB, filled=1. Same cycle: rsv addr 6 id 1 plus commit addr 6 old tag data 0x5 -> data 0x5, filled=0, tag 1.
5. Reserve regs 1,2,3 (busy_count=3), then pred_miss with simultaneous rsv addr 8 -> all filled=1, tags 0, busy_count=0, reg 8 not reserved.
6. ZERO_REG=1: rsv/commit addr 0 data 0xFF -> reads 0, filled=1. With RF_CMT_BYPASS_EN: commit addr 5 matching tag data 0x77 while reading 5 -> same-cycle rd_data=0x77, rd_filled=1. Without the macro -> old value this cycle, 0x77 the next.
